// File: rtl/tpu_pkg.sv
// Shared types and constants for the tpu datapath stages.
// Accumulator and activation element types, int8 bounds and the requant FSM encoding.
package tpu_pkg;

    localparam int SIZE_DEF = 2;

    typedef logic signed [31:0] acc_t;
    typedef logic signed [7:0]  act_t;

    localparam act_t INT8_MAX = act_t'(8'h7f);
    localparam act_t INT8_MIN = act_t'(8'h80);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_PUSH = 2'd2
    } requant_state_e;

endpackage

// File: rtl/requant_lane.sv
// Requantizes a single accumulator element to int8.
// The path applies optional ReLU, a round-half-up arithmetic shift, then saturation.
module requant_lane
    import tpu_pkg::*;
#(
    parameter int SHIFT_W = 5
) (
    input  acc_t               acc,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu,
    output act_t               value,
    output logic               sat
);

    localparam logic signed [32:0] Y_MAX = 33'sd127;
    localparam logic signed [32:0] Y_MIN = -33'sd128;

    logic signed [32:0] x_ext;
    logic signed [32:0] x_relu;
    logic signed [32:0] rnd_bias;
    logic signed [32:0] x_rnd;
    logic signed [32:0] y;
    logic [SHIFT_W-1:0] shift_m1;
    logic               sat_hi;
    logic               sat_lo;

    // 33 bits keep acc + 2^30 (the largest bias) from overflowing.
    always_comb begin
        x_ext    = {acc[31], acc};
        x_relu   = (relu && x_ext[32]) ? '0 : x_ext;
        shift_m1 = shift - SHIFT_W'(1);
        rnd_bias = (shift == '0) ? '0 : (33'sd1 <<< shift_m1);
        x_rnd    = x_relu + rnd_bias;
        y        = x_rnd >>> shift;
        sat_hi   = (y > Y_MAX);
        sat_lo   = (y < Y_MIN);
        sat      = sat_hi | sat_lo;
        if (sat_hi) begin
            value = INT8_MAX;
        end else if (sat_lo) begin
            value = INT8_MIN;
        end else begin
            value = act_t'(y[7:0]);
        end
    end

endmodule

// File: rtl/acc_requant.sv
// Drains one SIZE x SIZE accumulator matrix from the mmu, requantizes it one row
// per cycle and pushes the resulting int8 matrix downstream.
module acc_requant
    import tpu_pkg::*;
#(
    parameter int SIZE    = SIZE_DEF,
    parameter int SHIFT_W = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           acc_out_rdy,
    output logic                           acc_out_pop,
    input  acc_t [SIZE-1:0][SIZE-1:0]      acc_out,
    input  logic [SHIFT_W-1:0]             cfg_shift,
    input  logic                           cfg_relu,
    input  logic                           res_rdy,
    output logic                           res_push,
    output act_t [SIZE-1:0][SIZE-1:0]      res_out,
    output logic                           res_sat,
    output logic                           busy
);

    localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SIZE - 1);

    // Handshake: acc_out_pop and res_push are single-cycle transfer strobes; a
    // transfer happens on the rising edge where the strobe is high, which is
    // only ever when the partner's rdy is high and this block is in the state
    // that owns that side of the interface.

    requant_state_e            state;
    logic [ROW_W-1:0]          row;
    acc_t [SIZE-1:0][SIZE-1:0] acc_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic                      relu_q;

    act_t [SIZE-1:0]           lane_val;
    logic [SIZE-1:0]           lane_sat;

    for (genvar c = 0; c < SIZE; c++) begin : g_lane
        requant_lane #(
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .acc   (acc_q[row][c]),
            .shift (shift_q),
            .relu  (relu_q),
            .value (lane_val[c]),
            .sat   (lane_sat[c])
        );
    end

    always_comb begin
        acc_out_pop = rst_n && (state == S_IDLE) && acc_out_rdy;
        res_push    = rst_n && (state == S_PUSH) && res_rdy;
        busy        = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            row     <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            res_out <= '0;
            res_sat <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acc_out_rdy) begin
                        acc_q   <= acc_out;
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                        res_sat <= 1'b0;
                        row     <= '0;
                        state   <= S_PROC;
                    end
                end
                S_PROC: begin
                    // res_out doubles as the result buffer; it is only qualified in PUSH.
                    res_out[row] <= lane_val;
                    res_sat      <= res_sat | (|lane_sat);
                    row          <= row + 1'b1;
                    if (row == ROW_LAST) begin
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (res_rdy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant: hand-computed matrices, backpressure, throughput and reset.
// Pops enqueue the expected result; a monitor checks each push against the queue head.
module tb_acc_requant;
    import tpu_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 acc_out_rdy;
    logic                 acc_out_pop;
    acc_t [1:0][1:0]      acc_out;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu;
    logic                 res_rdy;
    logic                 res_push;
    act_t [1:0][1:0]      res_out;
    logic                 res_sat;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [32:0] exp_q[$];
    int          pop_cyc_q[$];
    bit          lat_q[$];
    logic [32:0] cur_exp;
    bit          exact_lat;

    logic [32:0] mon_exp;
    int          mon_pc;
    bit          mon_ex;

    acc_requant #(
        .SIZE    (2),
        .SHIFT_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_out_rdy (acc_out_rdy),
        .acc_out_pop (acc_out_pop),
        .acc_out     (acc_out),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .res_rdy     (res_rdy),
        .res_push    (res_push),
        .res_out     (res_out),
        .res_sat     (res_sat),
        .busy        (busy)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [127:0] mk_acc(input acc_t a00, input acc_t a01,
                                            input acc_t a10, input acc_t a11);
        return {a11, a10, a01, a00};
    endfunction

    function automatic logic [32:0] mk_exp(input act_t e00, input act_t e01,
                                           input act_t e10, input act_t e11,
                                           input logic sat);
        return {sat, e11, e10, e01, e00};
    endfunction

    // scoreboard: every pop enqueues the expected result of the matrix being driven
    always @(negedge clk) begin
        if (rst_n && acc_out_pop) begin
            exp_q.push_back(cur_exp);
            pop_cyc_q.push_back(cyc);
            lat_q.push_back(exact_lat);
        end
    end

    // monitor: every push is compared with the queue head
    always @(negedge clk) begin
        if (rst_n && res_push) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_push: got=%h expected=no push", {res_sat, res_out});
            end else begin
                mon_exp = exp_q.pop_front();
                mon_pc  = pop_cyc_q.pop_front();
                mon_ex  = lat_q.pop_front();
                check("push_data", {res_sat, res_out}, mon_exp);
                if (mon_ex) check("push_latency", 64'(cyc - mon_pc), 64'd3);
                else        check("push_latency_min", 64'(cyc - mon_pc >= 3), 64'd1);
            end
        end
    end

    // driver: present a matrix until it is popped, then withdraw it
    task automatic drive(input logic [127:0] m, input logic [4:0] sh, input logic rl,
                         input logic [32:0] e);
        bit popped;
        @(posedge clk); #1;
        acc_out     = m;
        cfg_shift   = sh;
        cfg_relu    = rl;
        cur_exp     = e;
        acc_out_rdy = 1'b1;
        popped      = 1'b0;
        for (int i = 0; i < 40 && !popped; i++) begin
            @(negedge clk);
            if (acc_out_pop) popped = 1'b1;
        end
        check("pop_seen", 64'(popped), 64'd1);
        @(posedge clk); #1;
        acc_out_rdy = 1'b0;
        if (popped) begin
            @(negedge clk);
            check("busy_after_pop", 64'(busy), 64'd1);
        end
    endtask

    task automatic wait_pop(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (acc_out_pop) begin
                ok = 1'b1;
                c  = cyc;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [127:0] m1, m2, m3, m4;
    logic [32:0]  e1, e2, e3, e4;

    initial begin
        int  prev, now;
        bit  ok;
        int  pushes;

        m1 = mk_acc(32'sd100, -32'sd100, 32'sd300, 32'sd5);
        e1 = mk_exp(8'sd100, -8'sd100, 8'sd127, 8'sd5, 1'b1);
        m2 = mk_acc(32'sd10, -32'sd10, 32'sd6, 32'sd7);
        e2 = mk_exp(8'sd3, -8'sd2, 8'sd2, 8'sd2, 1'b0);
        m3 = mk_acc(-32'sd5, 32'sd0, 32'sd200, -32'sd300);
        e3 = mk_exp(8'sd0, 8'sd0, 8'sd127, 8'sd0, 1'b1);
        m4 = mk_acc(32'h7fffffff, 32'h80000000, 32'sd0, -32'sd1);
        e4 = mk_exp(8'sd1, -8'sd1, 8'sd0, 8'sd0, 1'b0);

        rst_n       = 1'b0;
        acc_out_rdy = 1'b0;
        acc_out     = '0;
        cfg_shift   = '0;
        cfg_relu    = 1'b0;
        res_rdy     = 1'b0;
        cur_exp     = '0;
        exact_lat   = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pop",     64'(acc_out_pop), 64'd0);
        check("rst_push",    64'(res_push),    64'd0);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_res_out", 64'(res_out),     64'd0);
        check("rst_res_sat", 64'(res_sat),     64'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        res_rdy = 1'b1;

        // directed vectors, no backpressure
        drive(m1, 5'd0,  1'b0, e1);
        drive(m2, 5'd2,  1'b0, e2);
        drive(m3, 5'd0,  1'b1, e3);
        drive(m4, 5'd31, 1'b0, e4);
        drain();

        // backpressure: result held in PUSH while the next matrix waits
        res_rdy   = 1'b0;
        exact_lat = 1'b0;
        drive(m1, 5'd0, 1'b0, e1);
        acc_out     = m2;
        cfg_shift   = 5'd2;
        cfg_relu    = 1'b0;
        cur_exp     = e2;
        acc_out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_push",    64'(res_push),    64'd0);
            check("bp_pop",     64'(acc_out_pop), 64'd0);
            check("bp_res_out", 64'(res_out),     64'(e1[31:0]));
            check("bp_busy",    64'(busy),        64'd1);
        end
        @(posedge clk); #1;
        exact_lat = 1'b1;
        res_rdy   = 1'b1;
        @(negedge clk);
        check("release_push", 64'(res_push), 64'd1);
        @(negedge clk);
        check("pop_after_push", 64'(acc_out_pop), 64'd1);
        prev = cyc;

        // throughput: one pop every SIZE+2 cycles
        for (int k = 0; k < 3; k++) begin
            wait_pop(now, ok);
            check("pop_seen_tput", 64'(ok), 64'd1);
            if (ok) check("pop_interval", 64'(now - prev), 64'd4);
            prev = now;
        end
        @(posedge clk); #1;
        acc_out_rdy = 1'b0;
        drain();

        // reset in the middle of PROC discards the matrix
        drive(m2, 5'd2, 1'b0, e2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        pop_cyc_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy",    64'(busy),    64'd0);
        check("midrst_res_out", 64'(res_out), 64'd0);
        check("midrst_res_sat", 64'(res_sat), 64'd0);
        pushes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_push) pushes++;
        end
        check("midrst_no_push", 64'(pushes), 64'd0);

        // normal operation after reset
        drive(m3, 5'd0, 1'b1, e3);
        drive(m4, 5'd31, 1'b0, e4);
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got=no finish expected=finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/acc_requant.md
Name: acc_requant

Overview:
Downstream stage of the mmu. Drains one SIZE x SIZE 32-bit signed accumulator matrix through the mmu acc_out rdy/pop interface. Applies optional ReLU, a rounding arithmetic right shift and int8 saturation, then pushes the SIZE x SIZE int8 matrix to the next stage. That next stage is typically the activation FIFO feeding the next layer's data_in.

Parameters:
SIZE, 2, systolic array dimension; must equal the mmu SIZE.
SHIFT_W, 5, width of cfg_shift; shift range is 0..31.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  synchronous reset, active-low.
acc_out_rdy  in  1  mmu output FIFO holds a valid matrix.
acc_out_pop  out  1  consume the head matrix this cycle.
acc_out  in  [SIZE][SIZE] x 32  mmu head matrix, signed; valid while acc_out_rdy=1.
cfg_shift  in  SHIFT_W  right-shift amount; sampled at pop.
cfg_relu  in  1  ReLU enable; sampled at pop.
res_rdy  in  1  downstream has space for one matrix.
res_push  out  1  res_out is written downstream this cycle.
res_out  out  [SIZE][SIZE] x 8  requantized matrix, signed.
res_sat  out  1  at least one element of res_out was clamped to the int8 range.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n=0 at an edge): state goes to IDLE and row counter to 0. res_out, res_sat and the internal acc/config registers are cleared to 0.
  - Outputs during and after reset: acc_out_pop=0, res_push=0, busy=0.
  - Reset mid-operation discards the in-flight matrix, with no push.
- FSM states: IDLE, PROC, PUSH.
- IDLE:
  - acc_out_pop = acc_out_rdy (combinational from the state and the input).
  - On a pop edge: capture acc_out into acc_q, capture cfg_shift and cfg_relu, clear res_sat, set row=0, go to PROC.
- PROC:
  - Each cycle, requantize all SIZE lanes of row acc_q[row] into res_q[row] and increment row.
  - When row = SIZE-1, go to PUSH.
  - Exactly SIZE cycles in PROC.
- PUSH:
  - res_out holds res_q, stable for the whole state.
  - res_push = res_rdy (combinational).
  - On a push edge, go to IDLE.
  - Backpressure: with res_rdy=0, stay in PUSH indefinitely. acc_out_pop stays 0 even if acc_out_rdy=1.
- Timing:
  - Pop at edge T; first push possible in the cycle after edge T+SIZE.
  - Minimum interval between pops is SIZE+2 cycles.
  - No overlap of matrices; a single result buffer.
- Per-element arithmetic:
  - x = sign-extend(acc) to 33 bits.
  - If relu and x<0, then x=0.
  - If shift>0, x = x + (1 << (shift-1)) (round half up). The 33-bit width prevents overflow.
  - y = x >>> shift (arithmetic).
  - If y>127, output 127; if y<-128, output -128. Either case sets a sticky res_sat for this matrix.
  - ReLU zeroing does not set res_sat.
- res_out and res_sat hold their last values in IDLE; res_push qualifies them.

Decomposition:
- Shared package tpu_pkg: SIZE default, acc_t (logic signed [31:0]), act_t (logic signed [7:0]), INT8_MAX/INT8_MIN constants, and the FSM state enum requant_state_e.
- Sub-module requant_lane: combinational single element.
  - Inputs: acc_t, shift, relu.
  - Outputs: act_t value, sat flag.
  - Instantiated SIZE times, one per column.

Test Plan:
- SIZE=2, shift=0, relu=0, acc={{100,-100},{300,5}}:
  - pop 1 cycle, push after 2 PROC cycles.
  - res_out={{100,-100},{127,5}}, res_sat=1.
- shift=2, relu=0, acc={{10,-10},{6,7}} -> res_out={{3,-2},{2,2}}, res_sat=0.
- shift=0, relu=1, acc={{-5,0},{200,-300}} -> res_out={{0,0},{127,0}}, res_sat=1 (from 200 only).
- Width corner, shift=31, acc={{32'h7FFFFFFF,32'h80000000},{0,-1}} -> res_out={{1,-1},{0,0}}, res_sat=0.
- Backpressure and throughput: acc_out_rdy=1 held; res_rdy=0 for 5 cycles in PUSH.
  - res_out stable, res_push=0, acc_out_pop=0 throughout.
  - After release: push, then pop on the next cycle.
  - With res_rdy=1 held: pops every 4 cycles.
- Reset mid-PROC: rst_n=0 for one edge.
  - Next cycle busy=0, res_out=0, and no push ever occurs for that matrix.
  - Afterwards the next matrix processes normally.
